// File: rtl/fdc_pkg.sv
// Shared types and decode constants for the Z80-to-Wishbone FDC bridge.
// Holds the FSM state enum, A10/A8/A7 decode mask/values and FDC register map.
package fdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_HOLD = 2'd2
  } fdc_state_e;

  // Only A10, A8 and A7 take part in the port decode.
  localparam logic [15:0] DEC_MASK  = 16'h0580;
  localparam logic [15:0] DEC_FDC   = 16'h0100;
  localparam logic [15:0] DEC_MOTOR = 16'h0000;

  // FDC register map seen on the Wishbone side.
  localparam logic [2:0] FDC_REG_MSR  = 3'd0;
  localparam logic [2:0] FDC_REG_DATA = 3'd1;

  function automatic logic dec_match(
    input logic [15:0] a,
    input logic [15:0] v
  );
    return (a & DEC_MASK) == v;
  endfunction

  function automatic logic [2:0] fdc_reg(
    input logic a0
  );
    return a0 ? FDC_REG_DATA : FDC_REG_MSR;
  endfunction

endpackage

// File: rtl/fdc_z80_wb_bridge.sv
// Z80 I/O to Wishbone master bridge for an FDC, plus a motor latch port.
// Ports: wb_clk_i/wb_rst_i, Z80 bus (cpu_*), Wishbone master (wb_*),
// motor_o drive enables, timeout_o pulse on a forced termination.
module fdc_z80_wb_bridge
  import fdc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_m1_n,
  output logic [7:0]  cpu_dout,
  output logic        cpu_oe,
  output logic        cpu_wait_n,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [2:0]  wb_adr_o,
  output logic [7:0]  wb_dat_o,
  input  logic [7:0]  wb_dat_i,
  input  logic        wb_ack_i,
  output logic [1:0]  motor_o,
  output logic        timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  fdc_state_e      r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_cyc;
  logic            r_we;
  logic [2:0]      r_adr;
  logic [7:0]      r_dat;
  logic [7:0]      r_dout;
  logic            r_oe;
  logic [1:0]      r_motor;
  logic            r_timeout;

  logic w_io;
  logic w_fdc_hit;
  logic w_mot_hit;
  logic w_xfer_req;
  logic w_mot_wr;

  // M1 low with IORQ low is an interrupt acknowledge, not I/O.
  assign w_io       = ~cpu_iorq_n & cpu_m1_n;
  assign w_fdc_hit  = w_io & dec_match(cpu_addr, DEC_FDC);
  assign w_mot_hit  = w_io & dec_match(cpu_addr, DEC_MOTOR);
  assign w_xfer_req = w_fdc_hit & (~cpu_rd_n | ~cpu_wr_n);
  assign w_mot_wr   = w_mot_hit & ~cpu_wr_n;

  // WAIT pulls low in the detect cycle, before the FSM has moved.
  assign cpu_wait_n =
    ~((r_state == ST_IDLE && w_xfer_req) ||
      (r_state == ST_BUS));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= 3'd0;
      r_dat     <= 8'h00;
      r_dout    <= 8'hFF;
      r_oe      <= 1'b0;
      r_motor   <= 2'b00;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_xfer_req) begin
            r_state <= ST_BUS;
            r_cyc   <= 1'b1;
            r_we    <= ~cpu_wr_n;
            r_adr   <= fdc_reg(cpu_addr[0]);
            r_dat   <= cpu_din;
            r_cnt   <= '0;
          end else if (w_mot_wr) begin
            r_state <= ST_HOLD;
            r_motor <= {2{cpu_din[0]}};
          end
        end
        ST_BUS: begin
          // Z80 strobe is ignored here: a started
          // transfer always runs to ack or timeout.
          if (wb_ack_i) begin
            r_state <= ST_HOLD;
            r_cyc   <= 1'b0;
            r_oe    <= ~r_we;
            r_cnt   <= '0;
            if (!r_we) begin
              r_dout <= wb_dat_i;
            end
          end else if (r_cnt == C_LAST) begin
            r_state   <= ST_HOLD;
            r_cyc     <= 1'b0;
            r_oe      <= ~r_we;
            r_dout    <= 8'hFF;
            r_timeout <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          // Wait for the Z80 cycle to end so one
          // I/O cycle maps to one transfer.
          if (cpu_iorq_n) begin
            r_state <= ST_IDLE;
            r_oe    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cyc   <= 1'b0;
          r_oe    <= 1'b0;
        end
      endcase
    end
  end

  assign wb_cyc_o  = r_cyc;
  assign wb_stb_o  = r_cyc;
  assign wb_we_o   = r_we;
  assign wb_adr_o  = r_adr;
  assign wb_dat_o  = r_dat;
  assign cpu_dout  = r_dout;
  assign cpu_oe    = r_oe;
  assign motor_o   = r_motor;
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_fdc_z80_wb_bridge.sv
// Randomized self-checking bench for fdc_z80_wb_bridge.
// Transaction-level reference model plus directed literal scenarios.
module tb_fdc_z80_wb_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_din = 8'h00;
  logic        cpu_iorq_n = 1'b1;
  logic        cpu_rd_n = 1'b1;
  logic        cpu_wr_n = 1'b1;
  logic        cpu_m1_n = 1'b1;
  logic [7:0]  cpu_dout;
  logic        cpu_oe;
  logic        cpu_wait_n;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [2:0]  wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat_i = 8'h00;
  logic        wb_ack_i = 1'b0;
  logic [1:0]  motor_o;
  logic        timeout_o;

  always #5 clk = ~clk;

  fdc_z80_wb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_iorq_n(cpu_iorq_n),
    .cpu_rd_n  (cpu_rd_n),
    .cpu_wr_n  (cpu_wr_n),
    .cpu_m1_n  (cpu_m1_n),
    .cpu_dout  (cpu_dout),
    .cpu_oe    (cpu_oe),
    .cpu_wait_n(cpu_wait_n),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i),
    .motor_o   (motor_o),
    .timeout_o (timeout_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit is_fdc(input logic [15:0] a);
    return a[10] == 1'b0 && a[8] == 1'b1 && a[7] == 1'b0;
  endfunction

  function automatic bit is_mot(input logic [15:0] a);
    return a[10] == 1'b0 && a[8] == 1'b0 && a[7] == 1'b0;
  endfunction

  // Wishbone slave: acks s_lat clocks after stb first seen.
  int          s_lat = 1;
  int          s_cnt = 0;
  bit          s_spur = 1'b0;
  logic [7:0]  s_data = 8'h00;

  initial forever begin
    @(posedge clk);
    #1;
    if (wb_ack_i) begin
      wb_ack_i = 1'b0;
    end else if (wb_cyc_o && wb_stb_o) begin
      s_cnt++;
      if (s_cnt > s_lat) begin
        wb_ack_i = 1'b1;
        wb_dat_i = s_data;
        s_cnt = 0;
      end
    end else begin
      s_cnt = 0;
      wb_dat_i = 8'($urandom);
      wb_ack_i = s_spur && ($urandom_range(0, 5) == 0);
    end
  end

  // Reference model: one outstanding transfer per Z80 I/O cycle.
  bit         m_xfer = 0;
  bit         m_served = 0;
  bit         m_oe = 0;
  bit         m_we = 0;
  bit         m_to = 0;
  logic [7:0] m_dout = 8'hFF;
  logic [7:0] m_dat = 8'h00;
  logic [2:0] m_adr = 3'd0;
  logic [1:0] m_motor = 2'b00;
  int         m_age = 0;

  always @(posedge clk or posedge rst) begin
    bit io;
    if (rst) begin
      m_xfer = 0; m_served = 0; m_oe = 0; m_we = 0;
      m_to = 0; m_dout = 8'hFF; m_dat = 8'h00;
      m_adr = 3'd0; m_motor = 2'b00; m_age = 0;
    end else begin
      io = !cpu_iorq_n && cpu_m1_n;
      m_to = 0;
      if (m_xfer) begin
        m_age++;
        if (wb_ack_i) begin
          if (!m_we) m_dout = wb_dat_i;
          m_oe = !m_we;
          m_xfer = 0;
          m_served = 1;
        end else if (m_age == TO) begin
          m_dout = 8'hFF;
          m_oe = !m_we;
          m_to = 1;
          m_xfer = 0;
          m_served = 1;
        end
      end else if (m_served) begin
        if (cpu_iorq_n) begin
          m_served = 0;
          m_oe = 0;
        end
      end else if (io && is_fdc(cpu_addr) &&
                   (!cpu_rd_n || !cpu_wr_n)) begin
        m_xfer = 1;
        m_age = 0;
        m_we = !cpu_wr_n;
        m_adr = {2'b00, cpu_addr[0]};
        m_dat = cpu_din;
      end else if (io && is_mot(cpu_addr) && !cpu_wr_n) begin
        m_motor = {cpu_din[0], cpu_din[0]};
        m_served = 1;
      end
    end
  end

  // Compare process plus activity counters for directed checks.
  int         mon_stb = 0, mon_wait = 0, mon_to = 0;
  int         mon_rise = 0, mon_ack = 0, mon_oe = 0;
  bit         mon_prev = 0;
  logic [7:0] mon_oe_dout = 8'h00;
  logic [7:0] mon_dat = 8'h00;
  logic [2:0] mon_adr = 3'd0;
  logic       mon_we = 1'b0;

  always @(negedge clk) begin
    bit req;
    req = !cpu_iorq_n && cpu_m1_n && is_fdc(cpu_addr) &&
          (!cpu_rd_n || !cpu_wr_n);
    chk("cyc", wb_cyc_o, m_xfer);
    chk("stb", wb_stb_o, m_xfer);
    chk("wait_n", cpu_wait_n,
        !(m_xfer || (!m_served && req)));
    chk("oe", cpu_oe, m_oe);
    chk("dout", cpu_dout, m_dout);
    chk("motor", motor_o, m_motor);
    chk("timeout", timeout_o, m_to);
    if (m_xfer) begin
      chk("we", wb_we_o, m_we);
      chk("adr", wb_adr_o, m_adr);
      chk("dat_o", wb_dat_o, m_dat);
    end
    if (wb_stb_o) begin
      mon_stb++;
      mon_adr = wb_adr_o;
      mon_we = wb_we_o;
      mon_dat = wb_dat_o;
    end
    if (wb_stb_o && !mon_prev) mon_rise++;
    mon_prev = wb_stb_o;
    if (wb_stb_o && wb_ack_i) mon_ack++;
    if (!cpu_wait_n) mon_wait++;
    if (timeout_o) mon_to++;
    if (cpu_oe) begin
      mon_oe++;
      mon_oe_dout = cpu_dout;
    end
  end

  task automatic io(input logic [15:0] a, input bit rd,
                    input logic [7:0] d, input int extra,
                    input int abort_after, input bit m1);
    int n;
    int k;
    @(posedge clk);
    #1;
    cpu_addr = a;
    cpu_din = d;
    cpu_m1_n = m1;
    cpu_iorq_n = 1'b0;
    cpu_rd_n = !rd;
    cpu_wr_n = rd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_wait_n && n < 64 &&
               (abort_after == 0 || n < abort_after));
    chk("wait_bound", n < 64, 1);
    repeat (extra) @(negedge clk);
    @(posedge clk);
    #1;
    cpu_iorq_n = 1'b1;
    cpu_rd_n = 1'b1;
    cpu_wr_n = 1'b1;
    cpu_m1_n = 1'b1;
    k = 0;
    while (!cpu_wait_n && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk("release_bound", k < 64, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  int b_stb, b_wait, b_to, b_rise, b_ack, b_oe;

  task automatic snap();
    b_stb = mon_stb; b_wait = mon_wait; b_to = mon_to;
    b_rise = mon_rise; b_ack = mon_ack; b_oe = mon_oe;
  endtask

  initial begin
    #1 rst = 1'b1;
    #3;
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_we", wb_we_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_dout", cpu_dout, 8'hFF);
    chk("rst_oe", cpu_oe, 0);
    chk("rst_motor", motor_o, 0);
    chk("rst_to", timeout_o, 0);
    chk("rst_wait", cpu_wait_n, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Read FB7E, slave acks 0x80 one clock after stb.
    s_spur = 0; s_lat = 1; s_data = 8'h80;
    snap();
    io(16'hFB7E, 1, 8'h00, 0, 0, 1);
    chk("r_wait_clks", mon_wait - b_wait, 3);
    chk("r_stb_clks", mon_stb - b_stb, 2);
    chk("r_oe_seen", (mon_oe - b_oe) > 0, 1);
    chk("r_oe_dout", mon_oe_dout, 8'h80);
    chk("r_adr", mon_adr, 0);
    chk("r_we", mon_we, 0);
    chk("r_dout_hold", cpu_dout, 8'h80);

    // Write 03 to FB7F, strobe held 10 extra clocks.
    snap();
    io(16'hFB7F, 0, 8'h03, 10, 0, 1);
    chk("w_stb_rises", mon_rise - b_rise, 1);
    chk("w_acks", mon_ack - b_ack, 1);
    chk("w_we", mon_we, 1);
    chk("w_adr", mon_adr, 1);
    chk("w_dat", mon_dat, 8'h03);

    // Motor port.
    snap();
    io(16'hFA7E, 0, 8'h01, 0, 0, 1);
    chk("mot_on", motor_o, 2'b11);
    chk("mot_no_cyc", mon_rise - b_rise, 0);
    io(16'hFA7E, 0, 8'h00, 0, 0, 1);
    chk("mot_off", motor_o, 2'b00);
    snap();
    io(16'hFA7E, 1, 8'h00, 2, 0, 1);
    chk("mot_rd_oe", mon_oe - b_oe, 0);
    chk("mot_rd_wait", mon_wait - b_wait, 0);

    // Slave never acks: forced termination after 8 clocks.
    s_lat = 99;
    snap();
    io(16'hFB7E, 1, 8'h00, 0, 0, 1);
    chk("to_stb_clks", mon_stb - b_stb, 8);
    chk("to_pulses", mon_to - b_to, 1);
    chk("to_wait_clks", mon_wait - b_wait, 9);
    chk("to_dout", cpu_dout, 8'hFF);

    // Reset in BUS.
    io(16'hFA7E, 0, 8'h01, 0, 0, 1);
    @(posedge clk);
    #1;
    cpu_addr = 16'hFB7F;
    cpu_iorq_n = 1'b0;
    cpu_rd_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_cyc", wb_cyc_o, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cyc", wb_cyc_o, 0);
    chk("mid_rst_stb", wb_stb_o, 0);
    chk("mid_rst_motor", motor_o, 0);
    chk("mid_rst_wait_hit", cpu_wait_n, 0);
    cpu_iorq_n = 1'b1;
    cpu_rd_n = 1'b1;
    #1;
    chk("mid_rst_wait", cpu_wait_n, 1);
    @(negedge clk);
    rst = 1'b0;
    s_lat = 2; s_data = 8'h5A;
    io(16'hFB7F, 1, 8'h00, 0, 0, 1);
    chk("post_rst_dout", cpu_dout, 8'h5A);

    // Randomized traffic.
    s_spur = 1;
    repeat (250) begin
      logic [15:0] a;
      int sel;
      int ab;
      sel = $urandom_range(0, 3);
      a = 16'($urandom);
      if (sel < 2) a = (a & ~16'h0580) | 16'h0100;
      else if (sel == 2) a = a & ~16'h0580;
      s_lat = ($urandom_range(0, 9) == 0) ? 99 :
              $urandom_range(1, 10);
      s_data = 8'($urandom);
      ab = ($urandom_range(0, 6) == 0) ?
           $urandom_range(1, 4) : 0;
      io(a, 1'($urandom), 8'($urandom),
         $urandom_range(0, 3), ab,
         $urandom_range(0, 9) != 0);
    end

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fdc_z80_wb_bridge.md
FDC_Z80_WB_BRIDGE -- requirements
Module: fdc_z80_wb_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum clocks in BUS state before a forced termination.
REQ-002 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-003 wb_clk_i  in  1  system clock; all other inputs are synchronous to it.
REQ-004 wb_rst_i  in  1  asynchronous reset, active high.
REQ-005 cpu_addr  in  16  Z80 address bus.
REQ-006 cpu_din  in  8  Z80 write data.
REQ-007 cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n  in  1 each  Z80 strobes, active low.
REQ-008 cpu_dout  out  8  read data returned to the Z80.
REQ-009 cpu_oe  out  1  high while cpu_dout is driven onto the data bus.
REQ-010 cpu_wait_n  out  1  Z80 WAIT, active low.
REQ-011 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master strobes.
REQ-012 wb_adr_o  out  3  register address; wb_dat_o  out  8  write data.
REQ-013 wb_dat_i  in  8  read data; wb_ack_i  in  1  transfer acknowledge.
REQ-014 motor_o  out  2  drive motor enables, feeding the FDC motor input.
REQ-015 timeout_o  out  1  one-clock pulse on a forced termination.

Function
REQ-016 Decode, I/O only (iorq_n=0, m1_n=1): FDC hit = addr[10]=0, addr[8]=1, addr[7]=0; motor hit = addr[10]=0, addr[8]=0, addr[7]=0.
REQ-017 FSM states are IDLE, BUS and HOLD.
REQ-018 IDLE->BUS when an FDC hit occurs with rd_n=0 or wr_n=0; on that edge wb_cyc_o=wb_stb_o=1, wb_we_o=~wr_n, wb_adr_o={2'b00,addr[0]} and wb_dat_o=cpu_din are registered.
REQ-019 IDLE->HOLD on a motor hit with wr_n=0; motor_o<={cpu_din[0],cpu_din[0]} on the same edge; no Wishbone cycle is issued.
REQ-020 A motor-port read SHALL NOT be decoded: cpu_oe stays 0 and the FSM stays in IDLE.
REQ-021 In BUS, wb_adr_o, wb_we_o and wb_dat_o SHALL be held stable, with stb/cyc held high until wb_ack_i is sampled high.
REQ-022 On the edge that samples wb_ack_i=1: cyc/stb<=0, read data<=wb_dat_i (reads only), BUS->HOLD.
REQ-023 A second ack or spurious ack outside BUS SHALL be ignored.
REQ-024 A BUS counter runs; at TIMEOUT_CYCLES without ack: cyc/stb<=0, read data<=8'hFF, timeout_o pulses for one clock, BUS->HOLD.
REQ-025 HOLD->IDLE when cpu_iorq_n=1; this gives exactly one Wishbone transfer per Z80 I/O cycle.
REQ-026 cpu_wait_n SHALL be combinational, low when (IDLE and FDC hit with rd_n or wr_n low) or state=BUS, else high; WAIT asserts in the detect cycle.
REQ-027 cpu_oe=1 in HOLD for a read transfer only; cpu_dout holds the latched data from the BUS->HOLD edge until IDLE.
REQ-028 Minimum FDC access with a slave acking one clock after stb: detect edge N, stb high N+1..N+2, HOLD at N+3, WAIT released at N+3.
REQ-029 If the strobe is withdrawn in BUS (iorq_n=1), the transfer SHALL still complete or time out; it SHALL NOT be aborted.

Reset
REQ-030 Asynchronous reset SHALL force: state=IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=0, wb_dat_o=0, cpu_dout=8'hFF, cpu_oe=0, motor_o=2'b00, timeout_o=0, counter=0.
REQ-031 Reset mid-BUS SHALL drop cyc/stb immediately; cpu_wait_n goes high unless an FDC hit is still present in IDLE.

Structure
REQ-032 A shared package fdc_pkg SHALL hold the state enum, the decode masks/values (A10/A8/A7) and the FDC register address constants.
REQ-033 No sub-module; the FSM, decode and latches live in the single module.

Verification
REQ-034 Read addr 16'hFB7E with the slave acking 8'h80 one clock after stb: one cyc/stb pulse of 2 clocks, wb_adr_o=0, wb_we_o=0, cpu_dout=8'h80 with cpu_oe=1, WAIT low for exactly 3 clocks.
REQ-035 Write 8'h03 to 16'hFB7F: wb_we_o=1, wb_adr_o=1, wb_dat_o=8'h03; exactly one ack consumed; no second stb while iorq_n stays low for 10 clocks.
REQ-036 Write 8'h01 to 16'hFA7E: motor_o=2'b11, no cyc; write 8'h00: motor_o=2'b00; a read of 16'hFA7E gives cpu_oe=0 and WAIT high.
REQ-037 With the slave never acking and TIMEOUT_CYCLES=8: stb high for 8 clocks, then timeout_o pulses once, cpu_dout=8'hFF and WAIT is released.
REQ-038 Assert wb_rst_i in BUS: cyc/stb fall without a clock edge, motor_o=0 and state=IDLE; a next read to 16'hFB7F completes normally.
